multi_clk_div: RTL and testbench

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/multi_clk_div_pkg.sv | 21 ++
 rtl/multi_clk_div_chan.sv | 121 ++++++++++++
 rtl/multi_clk_div.sv | 53 +++++
 tb/tb_multi_clk_div.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clk_div_pkg.sv
// Shared types and configuration limits for the multi-channel clock divider.
// Optional tick output is enabled with `define MULTI_CLK_DIV_TICK_EN.
package multi_clk_div_pkg;

  localparam int unsigned NUM_CH_MIN   = 1;
  localparam int unsigned NUM_CH_MAX   = 16;
  localparam int unsigned RATIO_WD_MIN = 2;
  localparam int unsigned RATIO_WD_MAX = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOW  = 2'd1;
  localparam state_t ST_HIGH = 2'd2;

  function automatic bit cfg_in_range(input int unsigned num_ch, input int unsigned ratio_wd);
    return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
           (ratio_wd >= RATIO_WD_MIN) && (ratio_wd <= RATIO_WD_MAX);
  endfunction

endpackage

// File: rtl/multi_clk_div_chan.sv
// One divider channel: IDLE/LOW/HIGH FSM, phase counter, pending/active ratio, bypass mux.
// Optional o_tick logic is built when MULTI_CLK_DIV_TICK_EN is defined.
module clk_div_chan
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WD  = 8,
  parameter int unsigned DEF_RATIO = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [RATIO_WD-1:0] ratio,
  input  logic                upd,
  output logic                pend,
  output logic                div_clk
`ifdef MULTI_CLK_DIV_TICK_EN
  ,
  output logic                tick
`endif
);

  localparam logic [RATIO_WD-1:0] RATIO_ONE = RATIO_WD'(1);
  localparam logic [RATIO_WD-1:0] RATIO_TWO = RATIO_WD'(2);
  localparam logic [RATIO_WD-1:0] RATIO_DEF = RATIO_WD'(DEF_RATIO);
  localparam logic [RATIO_WD-2:0] CNT_ONE   = (RATIO_WD-1)'(1);

  state_t              st;
  logic [RATIO_WD-2:0] cnt;
  logic [RATIO_WD-1:0] n_act;
  logic [RATIO_WD-1:0] p_rat;
  logic                div_q;

  logic [RATIO_WD-1:0] half_lo;
  logic [RATIO_WD-1:0] half_hi;
  logic [RATIO_WD-1:0] cnt_ext;
  logic [RATIO_WD-1:0] next_n;
  logic                lo_done;
  logic                hi_done;
  logic                apply;
  logic                byp;
  logic                next_byp;

  always_comb begin
    half_lo  = n_act >> 1;
    half_hi  = n_act - half_lo;
    cnt_ext  = {1'b0, cnt};
    lo_done  = (cnt_ext == (half_lo - RATIO_ONE));
    hi_done  = (cnt_ext == (half_hi - RATIO_ONE));
    byp      = (n_act < RATIO_TWO);
    // Boundary is the last HIGH cycle; IDLE is always a safe point to swap ratios.
    apply    = pend && ((st == ST_IDLE) || ((st == ST_HIGH) && hi_done));
    next_n   = apply ? p_rat : n_act;
    next_byp = (next_n < RATIO_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      cnt   <= '0;
      div_q <= 1'b0;
      n_act <= RATIO_DEF;
      p_rat <= RATIO_DEF;
      pend  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          cnt   <= '0;
          div_q <= 1'b0;
          if (en && !next_byp) st <= ST_LOW;
        end
        ST_LOW: begin
          if (lo_done) begin
            st    <= ST_HIGH;
            cnt   <= '0;
            div_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (hi_done) begin
            cnt   <= '0;
            div_q <= 1'b0;
            st    <= (en && !next_byp) ? ST_LOW : ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          st    <= ST_IDLE;
          cnt   <= '0;
          div_q <= 1'b0;
        end
      endcase

      if (apply) begin
        n_act <= p_rat;
        pend  <= 1'b0;
      end
      // A strobe on the boundary edge lands after the swap, so it waits a full period.
      if (upd) begin
        p_rat <= ratio;
        pend  <= 1'b1;
      end
    end
  end

  assign div_clk = byp ? (clk & en & rst_n) : div_q;

`ifdef MULTI_CLK_DIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= (st == ST_LOW) && lo_done;
  end

  assign tick = tick_q | (byp & en & rst_n);
`endif

endmodule

// File: rtl/multi_clk_div.sv
// Array of NUM_CH independent clock dividers sharing one reference clock.
// Define MULTI_CLK_DIV_TICK_EN to add the per-channel o_tick output.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned RATIO_WD  = 8,
  parameter int unsigned DEF_RATIO = 2
) (
  input  logic                         i_ref_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_clk_en,
  input  logic [NUM_CH*RATIO_WD-1:0]   i_div_ratio,
  input  logic [NUM_CH-1:0]            i_ratio_upd,
  output logic [NUM_CH-1:0]            o_upd_pend,
  output logic [NUM_CH-1:0]            o_div_clk
`ifdef MULTI_CLK_DIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]            o_tick
`endif
);

  localparam bit CFG_OK = cfg_in_range(NUM_CH, RATIO_WD);

  if (CFG_OK) begin : g_chans
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clk_div_chan #(
        .RATIO_WD  (RATIO_WD),
        .DEF_RATIO (DEF_RATIO)
      ) u_chan (
        .clk     (i_ref_clk),
        .rst_n   (i_rst_n),
        .en      (i_clk_en[k]),
        .ratio   (i_div_ratio[k*RATIO_WD +: RATIO_WD]),
        .upd     (i_ratio_upd[k]),
        .pend    (o_upd_pend[k]),
        .div_clk (o_div_clk[k])
`ifdef MULTI_CLK_DIV_TICK_EN
        ,
        .tick    (o_tick[k])
`endif
      );
    end
  end else begin : g_bad_cfg
    // Out-of-range configuration: outputs parked low rather than building channels.
    assign o_upd_pend = '0;
    assign o_div_clk  = '0;
`ifdef MULTI_CLK_DIV_TICK_EN
    assign o_tick     = '0;
`endif
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed self-checking bench for multi_clk_div (4 channels, 8-bit ratios, DEF_RATIO=2).
module tb_multi_clk_div;

  localparam int unsigned NCH = 4;
  localparam int unsigned RW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    clk_en;
  logic [NCH*RW-1:0] div_ratio;
  logic [NCH-1:0]    ratio_upd;
  logic [NCH-1:0]    upd_pend;
  logic [NCH-1:0]    div_clk;
`ifdef MULTI_CLK_DIV_TICK_EN
  logic [NCH-1:0]    tick;
  int unsigned       tick_cnt = 0;
  int unsigned       rise_cnt = 0;
  logic [NCH-1:0]    prev_div = '0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  multi_clk_div #(
    .NUM_CH    (NCH),
    .RATIO_WD  (RW),
    .DEF_RATIO (2)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .i_ratio_upd (ratio_upd),
    .o_upd_pend  (upd_pend),
    .o_div_clk   (div_clk)
`ifdef MULTI_CLK_DIV_TICK_EN
    ,
    .o_tick      (tick)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ratio(input int unsigned ch, input int unsigned val);
    div_ratio[ch*RW +: RW] = RW'(val);
  endtask

  // Expected divided-clock level idx cycles after entering LOW.
  function automatic logic pat(input int unsigned idx, input int unsigned lo, input int unsigned hi);
    return logic'((idx % (lo + hi)) >= lo);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clk_en = '1;
    ratio_upd = '1;
    for (int unsigned c = 0; c < NCH; c++) set_ratio(c, 3);
    repeat (3) step();
    checks++;
    if (div_clk !== 4'b0000) begin
      errors++;
      $display("FAIL reset_div_clk got=%b want=%b", div_clk, 4'b0000);
    end
    checks++;
    if (upd_pend !== 4'b0000) begin
      errors++;
      $display("FAIL reset_upd_pend got=%b want=%b", upd_pend, 4'b0000);
    end
    @(negedge clk);
    #1;
    checks++;
    if (div_clk !== 4'b0000) begin
      errors++;
      $display("FAIL reset_div_clk_neg got=%b want=%b", div_clk, 4'b0000);
    end
    ratio_upd = '0;
    clk_en = '0;
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (div_clk !== 4'b0000 || upd_pend !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got=%b/%b want=0000/0000", div_clk, upd_pend);
    end
  endtask

  task automatic test_ratio2();
    clk_en[0] = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      checks++;
      if (div_clk[0] !== pat(i, 1, 1) || upd_pend[0] !== 1'b0) begin
        errors++;
        $display("FAIL ratio2 idx=%0d got=%b/%b want=%b/0", i, div_clk[0], upd_pend[0], pat(i, 1, 1));
      end
    end
    clk_en[0] = 1'b0;
    for (int unsigned j = 0; j < 3; j++) begin
      step();
      checks++;
      if (div_clk[0] !== 1'b0) begin
        errors++;
        $display("FAIL ratio2_stop idx=%0d got=%b want=0", j, div_clk[0]);
      end
    end
  endtask

  task automatic test_odd_even();
    set_ratio(1, 5);
    ratio_upd[1] = 1'b1;
    step();
    ratio_upd[1] = 1'b0;
    checks++;
    if (upd_pend[1] !== 1'b1) begin
      errors++;
      $display("FAIL r5_pend_set got=%b want=1", upd_pend[1]);
    end
    clk_en[1] = 1'b1;
    for (int unsigned i = 0; i < 50; i++) begin
      step();
      checks++;
      if (div_clk[1] !== pat(i, 2, 3) || (i == 0 && upd_pend[1] !== 1'b0)) begin
        errors++;
        $display("FAIL ratio5 idx=%0d got=%b/%b want=%b", i, div_clk[1], upd_pend[1], pat(i, 2, 3));
      end
    end
    clk_en[1] = 1'b0;
    set_ratio(1, 6);
    ratio_upd[1] = 1'b1;
    step();
    ratio_upd[1] = 1'b0;
    checks++;
    if (div_clk[1] !== 1'b0 || upd_pend[1] !== 1'b1) begin
      errors++;
      $display("FAIL r6_strobe got=%b/%b want=0/1", div_clk[1], upd_pend[1]);
    end
    step();
    checks++;
    if (div_clk[1] !== 1'b0 || upd_pend[1] !== 1'b0) begin
      errors++;
      $display("FAIL r6_idle_apply got=%b/%b want=0/0", div_clk[1], upd_pend[1]);
    end
    clk_en[1] = 1'b1;
    for (int unsigned i = 0; i < 60; i++) begin
      step();
      checks++;
      if (div_clk[1] !== pat(i, 3, 3)) begin
        errors++;
        $display("FAIL ratio6 idx=%0d got=%b want=%b", i, div_clk[1], pat(i, 3, 3));
      end
    end
    clk_en[1] = 1'b0;
    step();
    checks++;
    if (div_clk[1] !== 1'b0) begin
      errors++;
      $display("FAIL r6_stop got=%b want=0", div_clk[1]);
    end
  endtask

  task automatic test_pending_update();
    logic        exp_clk;
    logic        exp_pend;
    set_ratio(2, 4);
    ratio_upd[2] = 1'b1;
    step();
    ratio_upd[2] = 1'b0;
    clk_en[2] = 1'b1;
    for (int unsigned i = 0; i < 30; i++) begin
      step();
      if (i < 8)       exp_clk = pat(i, 2, 2);
      else if (i < 15) exp_clk = pat(i - 8, 3, 4);
      else if (i < 22) exp_clk = pat(i - 15, 3, 4);
      else             exp_clk = pat(i - 22, 2, 2);
      exp_pend = ((i >= 5 && i <= 7) || (i >= 15 && i <= 21)) ? 1'b1 : 1'b0;
      checks++;
      if (div_clk[2] !== exp_clk || upd_pend[2] !== exp_pend) begin
        errors++;
        $display("FAIL pend_upd idx=%0d got=%b/%b want=%b/%b", i, div_clk[2], upd_pend[2], exp_clk, exp_pend);
      end
      if (i == 4) begin
        set_ratio(2, 7);
        ratio_upd[2] = 1'b1;
      end else if (i == 14) begin
        set_ratio(2, 4);
        ratio_upd[2] = 1'b1;
      end else begin
        ratio_upd[2] = 1'b0;
      end
    end
    clk_en[2] = 1'b0;
    step();
    checks++;
    if (div_clk[2] !== 1'b0) begin
      errors++;
      $display("FAIL pend_upd_stop got=%b want=0", div_clk[2]);
    end
  endtask

  task automatic test_stop_restart();
    set_ratio(3, 8);
    ratio_upd[3] = 1'b1;
    step();
    ratio_upd[3] = 1'b0;
    clk_en[3] = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      step();
      checks++;
      if (div_clk[3] !== pat(i, 4, 4)) begin
        errors++;
        $display("FAIL stop_finish idx=%0d got=%b want=%b", i, div_clk[3], pat(i, 4, 4));
      end
      if (i == 12) clk_en[3] = 1'b0;
    end
    for (int unsigned j = 0; j < 6; j++) begin
      step();
      checks++;
      if (div_clk[3] !== 1'b0) begin
        errors++;
        $display("FAIL stop_held idx=%0d got=%b want=0", j, div_clk[3]);
      end
    end
    clk_en[3] = 1'b1;
    for (int unsigned i = 0; i < 24; i++) begin
      step();
      checks++;
      if (div_clk[3] !== pat(i, 4, 4)) begin
        errors++;
        $display("FAIL restart_cancel idx=%0d got=%b want=%b", i, div_clk[3], pat(i, 4, 4));
      end
      if (i == 13) clk_en[3] = 1'b0;
      if (i == 14) clk_en[3] = 1'b1;
    end
    clk_en[3] = 1'b0;
    step();
    checks++;
    if (div_clk[3] !== 1'b0) begin
      errors++;
      $display("FAIL restart_stop got=%b want=0", div_clk[3]);
    end
  endtask

  task automatic test_bypass();
    set_ratio(0, 3);
    ratio_upd[0] = 1'b1;
    step();
    ratio_upd[0] = 1'b0;
    clk_en[0] = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      checks++;
      if (div_clk[0] !== pat(i, 1, 2) || ((i >= 4) && upd_pend[0] !== 1'b1)) begin
        errors++;
        $display("FAIL r3_to_byp idx=%0d got=%b/%b want=%b", i, div_clk[0], upd_pend[0], pat(i, 1, 2));
      end
      if (i == 3) begin
        set_ratio(0, 1);
        ratio_upd[0] = 1'b1;
      end else begin
        ratio_upd[0] = 1'b0;
      end
    end
    for (int unsigned j = 0; j < 4; j++) begin
      step();
      checks++;
      if (div_clk[0] !== 1'b1 || upd_pend[0] !== 1'b0) begin
        errors++;
        $display("FAIL byp_high idx=%0d got=%b/%b want=1/0", j, div_clk[0], upd_pend[0]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (div_clk[0] !== 1'b0) begin
        errors++;
        $display("FAIL byp_low idx=%0d got=%b want=0", j, div_clk[0]);
      end
    end
    step();
    clk_en[0] = 1'b0;
    #1;
    checks++;
    if (div_clk[0] !== 1'b0) begin
      errors++;
      $display("FAIL byp_disabled got=%b want=0", div_clk[0]);
    end
    clk_en[0] = 1'b1;
    set_ratio(0, 3);
    ratio_upd[0] = 1'b1;
    step();
    ratio_upd[0] = 1'b0;
    checks++;
    if (div_clk[0] !== 1'b1 || upd_pend[0] !== 1'b1) begin
      errors++;
      $display("FAIL byp_exit_strobe got=%b/%b want=1/1", div_clk[0], upd_pend[0]);
    end
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      checks++;
      if (div_clk[0] !== pat(i, 1, 2) || upd_pend[0] !== 1'b0) begin
        errors++;
        $display("FAIL byp_to_r3 idx=%0d got=%b/%b want=%b/0", i, div_clk[0], upd_pend[0], pat(i, 1, 2));
      end
    end
    clk_en[0] = 1'b0;
    step();
    checks++;
    if (div_clk[0] !== 1'b0) begin
      errors++;
      $display("FAIL byp_r3_stop got=%b want=0", div_clk[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [NCH-1:0] exp;
    set_ratio(0, 3);
    set_ratio(1, 5);
    set_ratio(2, 6);
    set_ratio(3, 8);
    ratio_upd = '1;
    step();
    ratio_upd = '0;
    clk_en = '1;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      exp = {pat(i, 4, 4), pat(i, 3, 3), pat(i, 2, 3), pat(i, 1, 2)};
      checks++;
      if (div_clk !== exp) begin
        errors++;
        $display("FAIL all_run idx=%0d got=%b want=%b", i, div_clk, exp);
      end
`ifdef MULTI_CLK_DIV_TICK_EN
      for (int unsigned c = 0; c < NCH; c++) begin
        if (div_clk[c] && !prev_div[c]) rise_cnt++;
        if (tick[c]) tick_cnt++;
      end
      prev_div = div_clk;
`endif
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (div_clk !== 4'b0000 || upd_pend !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got=%b/%b want=0000/0000", div_clk, upd_pend);
    end
    @(negedge clk);
    #1;
    checks++;
    if (div_clk !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_neg got=%b want=0000", div_clk);
    end
    rst_n = 1'b1;
`ifdef MULTI_CLK_DIV_TICK_EN
    prev_div = '0;
`endif
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      exp = pat(i, 1, 1) ? 4'b1111 : 4'b0000;
      checks++;
      if (div_clk !== exp) begin
        errors++;
        $display("FAIL def_ratio idx=%0d got=%b want=%b", i, div_clk, exp);
      end
`ifdef MULTI_CLK_DIV_TICK_EN
      for (int unsigned c = 0; c < NCH; c++) begin
        if (div_clk[c] && !prev_div[c]) rise_cnt++;
        if (tick[c]) tick_cnt++;
      end
      prev_div = div_clk;
`endif
    end
    clk_en = '0;
    step();
    checks++;
    if (div_clk !== 4'b0000) begin
      errors++;
      $display("FAIL def_ratio_stop got=%b want=0000", div_clk);
    end
`ifdef MULTI_CLK_DIV_TICK_EN
    checks++;
    if (tick_cnt !== rise_cnt) begin
      errors++;
      $display("FAIL tick_count got=%0d want=%0d", tick_cnt, rise_cnt);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    clk_en    = '0;
    div_ratio = '0;
    ratio_upd = '0;
    test_reset();
    test_ratio2();
    test_odd_even();
    test_pending_update();
    test_stop_restart();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
